// File: rtl/conv_s2_window_seq_if.sv
// conv_s2_window_seq_if: RAM read port and pixel stream between the window sequencer and its neighbours
interface conv_s2_window_seq_if #(
  parameter int DW = 16,
  parameter int AW = 10
);
  logic          ram_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_dout;
  logic          pix_valid;
  logic          pix_ready;
  logic [DW-1:0] pix_data;
  logic          pix_last_tap;
  logic          pix_last_win;
  modport master (
    output ram_en, ram_addr, pix_valid, pix_data, pix_last_tap, pix_last_win,
    input  ram_dout, pix_ready
  );
  modport slave (
    input  ram_en, ram_addr, pix_valid, pix_data, pix_last_tap, pix_last_win,
    output ram_dout, pix_ready
  );
endinterface

// File: rtl/conv_s2_window_seq.sv
// conv_s2_window_seq: walks 3x3 stride-2 windows of one feature-map bank and streams pixels with credit-limited reads
module conv_s2_window_seq #(
  parameter int MAP_W     = 9,
  parameter int MAP_H     = 9,
  parameter int K         = 3,
  parameter int STRIDE    = 2,
  parameter int DW        = 16,
  parameter int AW        = 10,
  parameter int BANK_SIZE = 81
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic bank,
  output logic busy,
  output logic done,
  conv_s2_window_seq_if.master bus
);
  localparam int NW = (MAP_W - K) / STRIDE + 1;
  localparam int NH = (MAP_H - K) / STRIDE + 1;
  localparam int MX = (NW > K) ? ((NW > NH) ? NW : NH) : ((K > NH) ? K : NH);
  localparam int CW = (MX > 1) ? $clog2(MX) : 1;
  localparam logic [CW-1:0] KM = CW'(K - 1);
  localparam logic [CW-1:0] WM = CW'(NW - 1);
  localparam logic [CW-1:0] HM = CW'(NH - 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t st, st_n;
  logic [CW-1:0] kx, ky, wc, wr;
  logic bank_q, rd_q, lt_q, lw_q, done_q, wp, rp;
  logic [1:0] cnt;
  logic [AW-1:0] addr_q, cur_addr;
  logic [DW-1:0] fd [2];
  logic ft [2], fw [2];
  logic pop, issue, lt_c, lw_c, last_rd, fin, go;
  always_comb begin
    cur_addr = AW'((bank_q ? BANK_SIZE : 0) + (int'(wr) * STRIDE + int'(ky)) * MAP_W
                   + int'(wc) * STRIDE + int'(kx));
    pop      = (cnt != 2'd0) && bus.pix_ready;
    // a read now lands two cycles later; the FIFO must have room for it and the one in flight
    issue    = (st == RUN) && ({1'b0, cnt} + {2'b0, rd_q} <= 3'd1 + {2'b0, pop});
    lt_c     = (kx == KM) && (ky == KM);
    lw_c     = (wc == WM) && (wr == HM);
    last_rd  = lt_c && lw_c;
    fin      = (st == DRAIN) && pop && ft[rp] && fw[rp];
    go       = (st == IDLE) && start && !done_q;
    st_n     = go ? RUN : (st == RUN && issue && last_rd) ? DRAIN : fin ? IDLE : st;
  end
  assign busy             = st != IDLE;
  assign done             = done_q;
  assign bus.ram_en       = issue;
  assign bus.ram_addr     = issue ? cur_addr : addr_q;
  assign bus.pix_valid    = cnt != 2'd0;
  assign bus.pix_data     = fd[rp];
  assign bus.pix_last_tap = ft[rp];
  assign bus.pix_last_win = fw[rp];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st     <= IDLE;
      kx     <= '0;
      ky     <= '0;
      wc     <= '0;
      wr     <= '0;
      bank_q <= 1'b0;
      rd_q   <= 1'b0;
      lt_q   <= 1'b0;
      lw_q   <= 1'b0;
      done_q <= 1'b0;
      addr_q <= '0;
      wp     <= 1'b0;
      rp     <= 1'b0;
      cnt    <= 2'd0;
      fd     <= '{default: '0};
      ft     <= '{default: 1'b0};
      fw     <= '{default: 1'b0};
    end else begin
      st     <= st_n;
      done_q <= fin;
      rd_q   <= issue;
      lt_q   <= lt_c;
      lw_q   <= lw_c;
      if (go) begin
        bank_q <= bank;
        kx     <= '0;
        ky     <= '0;
        wc     <= '0;
        wr     <= '0;
      end else if (issue) begin
        addr_q <= cur_addr;
        kx     <= (kx == KM) ? '0 : kx + 1'b1;
        ky     <= (kx == KM) ? ((ky == KM) ? '0 : ky + 1'b1) : ky;
        wc     <= lt_c ? ((wc == WM) ? '0 : wc + 1'b1) : wc;
        wr     <= (lt_c && wc == WM) ? ((wr == HM) ? '0 : wr + 1'b1) : wr;
      end
      if (rd_q) begin
        fd[wp] <= bus.ram_dout;
        ft[wp] <= lt_q;
        fw[wp] <= lw_q;
        wp     <= ~wp;
      end
      if (pop) rp <= ~rp;
      cnt <= cnt + {1'b0, rd_q} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_conv_s2_window_seq.sv
// tb_conv_s2_window_seq: directed passes with a RAM model, a FIFO occupancy model and a table of hand-computed pixels
module tb_conv_s2_window_seq;
  logic clk = 1'b0, rst_n, start, bank;
  logic busy, done;
  conv_s2_window_seq_if #(.DW(16), .AW(10)) bus ();
  conv_s2_window_seq dut (.clk(clk), .rst_n(rst_n), .start(start), .bank(bank),
                          .busy(busy), .done(done), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {logic bnk; int idx; int d; logic lt; logic lw;} vec_t;
  vec_t vt [31];
  logic [15:0] ram [0:161];
  logic [15:0] cd[$];
  logic ctap[$], cwin[$];
  int cyc = 0, t0 = 0, total = 0, bad = 0, rmode = 0, b_cur = 0;
  int nreads, ndone, first_en, first_v, done_rel, early, occ, infl;
  int busy_h [0:399];
  logic pv, pr, ptap, pwin;
  logic [15:0] pd;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk)
    if (bus.ram_en) bus.ram_dout <= (bus.ram_addr < 10'd162) ? ram[bus.ram_addr[7:0]] : 16'hdead;
  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", n, act, exp);
    end
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    bus.pix_ready = (rmode == 1) ? 1'($urandom_range(0, 1)) :
                    (rmode == 2) ? !((cyc - t0) >= 1 && (cyc - t0) <= 20) : 1'b1;
  end
  always @(negedge clk) begin
    int rel, pop;
    rel = cyc - t0;
    if (!rst_n) begin
      chk("rst_ctl", int'({busy, done, bus.ram_en, bus.pix_valid, bus.pix_last_tap, bus.pix_last_win}), 0);
      chk("rst_addr", int'(bus.ram_addr), 0);
      chk("rst_data", int'(bus.pix_data), 0);
      occ = 0;
      infl = 0;
      pv = 0;
    end else begin
      pop = int'(bus.pix_valid && bus.pix_ready);
      if (bus.ram_en) begin
        nreads++;
        if (first_en < 0) first_en = rel;
        if (rel >= 1 && rel <= 20) early++;
        chk("addr_range", int'(int'(bus.ram_addr) >= b_cur * 81 && int'(bus.ram_addr) < b_cur * 81 + 81), 1);
        chk("credit", int'(occ + infl - pop <= 1), 1);
      end
      chk("valid_vs_occ", int'(bus.pix_valid), int'(occ != 0));
      if (pv && !pr) begin
        chk("stall_valid", int'(bus.pix_valid), 1);
        chk("stall_data", int'(bus.pix_data), int'(pd));
        chk("stall_flags", int'({bus.pix_last_tap, bus.pix_last_win}), int'({ptap, pwin}));
      end
      if (bus.pix_valid && first_v < 0) first_v = rel;
      if (pop != 0) begin
        cd.push_back(bus.pix_data);
        ctap.push_back(bus.pix_last_tap);
        cwin.push_back(bus.pix_last_win);
      end
      if (done) begin
        ndone++;
        done_rel = rel;
      end
      if (rel >= 0 && rel < 400) busy_h[rel] = int'(busy);
      occ = occ + infl - pop;
      if (infl != 0) chk("occ_max", int'(occ <= 2), 1);
      infl = int'(bus.ram_en);
      pv = bus.pix_valid;
      pr = bus.pix_ready;
      pd = bus.pix_data;
      ptap = bus.pix_last_tap;
      pwin = bus.pix_last_win;
    end
  end
  task automatic do_start(input int b);
    @(posedge clk);
    #1;
    start = 1'b1;
    bank = b[0];
    b_cur = b;
    t0 = cyc;
    nreads = 0;
    ndone = 0;
    first_en = -1;
    first_v = -1;
    done_rel = -1;
    early = 0;
    cd.delete();
    ctap.delete();
    cwin.delete();
    for (int i = 0; i < 400; i++) busy_h[i] = -1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask
  task automatic wait_done();
    int n = 0;
    while (ndone == 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", int'(ndone != 0), 1);
    repeat (3) @(negedge clk);
  endtask
  task automatic check_pass(input int b);
    chk("pix_count", cd.size(), 144);
    for (int i = 0; i < cd.size() && i < 144; i++) begin
      int w, t, e;
      w = i / 9;
      t = i % 9;
      e = b * 81 + ((w / 4) * 2 + t / 3) * 9 + (w % 4) * 2 + t % 3;
      chk($sformatf("pix%0d_data", i), int'(cd[i]), e);
      chk($sformatf("pix%0d_tap", i), int'(ctap[i]), int'(t == 8));
      chk($sformatf("pix%0d_win", i), int'(cwin[i]), int'(w == 15));
    end
  endtask
  task automatic run_table(input int b);
    foreach (vt[i])
      if (int'(vt[i].bnk) == b && vt[i].idx < cd.size()) begin
        chk($sformatf("vec%0d_data", i), int'(cd[vt[i].idx]), vt[i].d);
        chk($sformatf("vec%0d_flags", i), int'({ctap[vt[i].idx], cwin[vt[i].idx]}), int'({vt[i].lt, vt[i].lw}));
      end
  endtask
  initial begin
    int w0 [9] = '{0, 1, 2, 9, 10, 11, 18, 19, 20};
    int w1 [9] = '{2, 3, 4, 11, 12, 13, 20, 21, 22};
    int w15 [9] = '{60, 61, 62, 69, 70, 71, 78, 79, 80};
    for (int t = 0; t < 9; t++) begin
      vt[t]      = '{1'b0, t, w0[t], t == 8, 1'b0};
      vt[9 + t]  = '{1'b0, 9 + t, w1[t], t == 8, 1'b0};
      vt[18 + t] = '{1'b0, 135 + t, w15[t], t == 8, 1'b1};
    end
    vt[27] = '{1'b1, 0, 81, 1'b0, 1'b0};
    vt[28] = '{1'b1, 8, 101, 1'b1, 1'b0};
    vt[29] = '{1'b1, 9, 83, 1'b0, 1'b0};
    vt[30] = '{1'b1, 143, 161, 1'b1, 1'b1};
    for (int a = 0; a < 162; a++) ram[a] = 16'(a);
    rst_n = 1'b0;
    start = 1'b0;
    bank = 1'b0;
    bus.pix_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_start(0);
    wait_done();
    chk("busy_c0", busy_h[0], 0);
    chk("busy_c1", busy_h[1], 1);
    chk("first_en", first_en, 1);
    chk("first_valid", first_v, 3);
    chk("busy_c146", busy_h[146], 1);
    chk("done_cycle", done_rel, 147);
    chk("busy_c147", busy_h[147], 0);
    chk("reads", nreads, 144);
    chk("dones", ndone, 1);
    check_pass(0);
    run_table(0);
    do_start(1);
    wait_done();
    chk("b1_done_cycle", done_rel, 147);
    check_pass(1);
    run_table(1);
    rmode = 1;
    do_start(0);
    wait_done();
    chk("rnd_reads", nreads, 144);
    chk("rnd_dones", ndone, 1);
    check_pass(0);
    rmode = 0;
    do_start(0);
    bank = 1'b1;
    for (int k = 0; k < 160; k++) begin
      @(posedge clk);
      #1;
      start = ((cyc - t0) == 10 || (cyc - t0) == 60 || (cyc - t0) == 147);
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("ign_dones", ndone, 1);
    chk("ign_done_cycle", done_rel, 147);
    chk("ign_busy148", busy_h[148], 0);
    chk("ign_busy150", busy_h[150], 0);
    chk("ign_reads", nreads, 144);
    check_pass(0);
    do_start(0);
    do begin
      @(posedge clk);
      #1;
    end while (cyc - t0 < 50);
    rst_n = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_no_done", ndone, 0);
    chk("rst_idle", int'({busy, bus.pix_valid}), 0);
    do_start(0);
    wait_done();
    chk("post_rst_done_cycle", done_rel, 147);
    check_pass(0);
    rmode = 2;
    do_start(0);
    wait_done();
    chk("stall_reads", early, 2);
    chk("stall_dones", ndone, 1);
    check_pass(0);
    rmode = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/conv_s2_window_seq.md
# conv_s2_window_seq

Read sequencer for the 162 x 16-bit dual-port feature-map RAM in the 2D stride-2 convolution path. On a start pulse it walks every 3x3 stride-2 window of one 9x9 bank (bank 0 at words 0..80, bank 1 at 81..161) through the RAM read port. It streams the fetched pixels to the MAC stage over a valid/ready interface. It owns only the read port; the writer keeps the other port.

## Interface
Parameters:
- MAP_W, 9, map width in words (column 8 is zero padding)
- MAP_H, 9, map height (row 8 is zero padding)
- K, 3, kernel size
- STRIDE, 2, window step
- DW, 16, data width
- AW, 10, RAM address width
- BANK_SIZE, 81, words per bank

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a pass; sampled only in IDLE
- bank  in  1  bank select, latched on accepted start
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse after the last pixel handshake
- ram_en  out  1  read enable to the RAM port
- ram_addr  out  AW  read address
- ram_dout  in  DW  RAM read data, valid the cycle after ram_en
- pix_valid  out  1  output pixel valid
- pix_ready  in  1  consumer ready
- pix_data  out  DW  output pixel
- pix_last_tap  out  1  last (9th) tap of the current window
- pix_last_win  out  1  pixel belongs to the last (16th) window

## Operation
- Geometry: windows per axis = (MAP_W-K)/STRIDE+1 = 4, giving 16 windows and 144 reads per pass.
- Address = base + (wr*STRIDE+ky)*MAP_W + (wc*STRIDE+kx).
  - base = bank ? BANK_SIZE : 0.
  - wr, wc range 0..3; ky, kx range 0..2.
- Order: windows row-major (wc fastest). Inside each window, taps row-major (kx fastest).
- Counters are kx, ky, wc, wr. Each wraps at its limit and carries into the next. All arithmetic is unsigned; the maximum address is 161 and fits in AW.
- States:
  - IDLE: start=1 moves to RUN. Latch bank, clear counters.
  - RUN: issue reads under credit. After the 144th read is issued, move to DRAIN.
  - DRAIN: no reads. When the pixel with last_win&last_tap completes its handshake, move to IDLE and pulse done.
- Output buffer: 2-entry FIFO carrying data plus both last flags, which travel with their read.
  - Each RAM return is pushed in the cycle it appears.
  - A pop happens on pix_valid & pix_ready.
- Credit rule: a read may issue in cycle t only if fifo_count + inflight − pop_t ≤ 1. inflight is 1 if a read was issued in t−1. The FIFO therefore never overflows.
- Backpressure is lossless: no pixel is dropped or duplicated, and order is preserved.
- While pix_valid=1 and pix_ready=0, pix_data and both flags stay stable.
- start is ignored while busy, including in the cycle done is high.
- Reset mid-pass: all state clears immediately. The FIFO is flushed, no done pulse is produced, and the block returns to IDLE.
- Reset values: busy 0, done 0, ram_en 0, ram_addr 0, pix_valid 0, pix_data 0, pix_last_tap 0, pix_last_win 0.
- ram_addr holds its last value when ram_en=0.

## Timing
- Cycle numbering: start is sampled at edge 0.
  - busy=1 and the first ram_en fall in cycle 1.
  - ram_dout is valid in cycle 2 and captured at the end of cycle 2.
  - First pix_valid is in cycle 3.
- Latency from ram_en to pix_valid is 2 cycles.
- Throughput with pix_ready held at 1 is one pixel per cycle.
  - Reads occupy cycles 1..144.
  - The last pixel handshakes in cycle 146.
  - done=1 in cycle 147, and busy=0 from cycle 147.
- A new start is accepted in cycle 148 at the earliest.

## Test plan
- Preload ram[a]=a, bank=0, pix_ready=1:
  - Window 0 emits 0,1,2,9,10,11,18,19,20.
  - Window 1 emits 2,3,4,11,12,13,20,21,22.
  - Window 15 emits 60,61,62,69,70,71,78,79,80.
  - pix_last_tap on every 9th pixel; pix_last_win on the final 9.
  - done in cycle 147.
- bank=1, same preload: each pixel is its bank-0 value +81, the last pixel is 161, and no address exceeds 161.
- pix_ready driven by pseudo-random 50% duty:
  - Exactly 144 pixels, in the same order as the first scenario.
  - Data and flags stable while stalled.
  - FIFO count never exceeds 2.
  - ram_en never issues a read that violates the credit rule.
- start pulsed in cycles 10, 60 and 147 of a pass: all ignored, and exactly one done per pass.
- rst_n low in cycle 50, released in cycle 53:
  - All outputs at reset values during reset, and no done.
  - A new start then gives a complete, correct pass from address base.
- pix_ready=0 from cycle 1 for 20 cycles: only 2 reads issue. Normal streaming resumes after ready rises, and the pass still totals 144 pixels.
